status_flags: RTL
=================

Name: status_flags

Overview:
- Producer side of the branch-condition interface: owns the CPU's carry, overflow, zero and negative flags consumed by branch evaluation.
- Computes flags from ALU results, supports direct flag writes, and chains multi-byte compares.
- Keeps a small shadow stack so flags survive interrupt entry/return.
- Sits between the ALU and the branch checker in the execute stage.

Parameters:
- WIDTH, 8, ALU data width in bits; MSB index is WIDTH-1.
- SHADOW_DEPTH, 4, number of flag sets the interrupt shadow stack holds (power of 2, >=2).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- update  in  1  load flags from ALU result this cycle.
- op_class  in  2  00 logic, 01 add, 10 sub, 11 sub-chained (multi-byte compare/subtract).
- a  in  WIDTH  ALU operand A.
- b  in  WIDTH  ALU operand B, as applied to the ALU (not pre-inverted).
- result  in  WIDTH  ALU result.
- alu_carry  in  1  ALU carry-out (add) or borrow-out (sub: 1 when borrow occurred).
- flag_write  in  1  direct write of all four flags.
- flag_wdata  in  4  {carry, overflow, zero, negative} for flag_write.
- save  in  1  push current flags (interrupt entry).
- restore  in  1  pop flags (return from interrupt).
- err_clear  in  1  clear stack_err.
- carry, overflow, zero, negative  out  1 each  registered flags.
- shadow_empty  out  1  stack holds 0 entries.
- shadow_full  out  1  stack holds SHADOW_DEPTH entries.
- stack_err  out  1  sticky push-on-full / pop-on-empty / save+restore conflict.

Behaviour:
- Reset (async, rst_n low): all four flags 0, stack count 0, shadow_empty 1, shadow_full 0, stack_err 0. Reset mid-operation discards stack contents and any pending request.
- All outputs registered. A request in cycle N is visible at outputs in cycle N+1; no combinational path from inputs to outputs.
- Flag computation on update (M = WIDTH-1):
  - negative = result[M], all classes.
  - zero = (result == 0) for classes 00/01/10. Class 11: zero = (result == 0) AND current zero.
  - carry: unchanged for class 00; alu_carry for 01/10/11.
  - overflow: 0 for class 00.
  - overflow for class 01: (a[M] == b[M]) AND (result[M] != a[M]).
  - overflow for classes 10/11: (a[M] != b[M]) AND (result[M] != a[M]).
- Priority per cycle: restore > save > flag_write > update.
- restore alone, stack non-empty: flags <= top entry, count decrements. flag_write and update in the same cycle are ignored.
- restore with stack empty: flags unchanged, count stays 0, stack_err <= 1. flag_write and update are also ignored.
- save alone, stack not full: push flags as registered at the start of the cycle (pre-update), count increments. A flag_write or update in the same cycle still applies to the live flags.
- save with stack full: push dropped, stack_err <= 1. Live flags still take any same-cycle flag_write or update.
- save AND restore in the same cycle: neither executes, stack and flags unchanged, stack_err <= 1.
- flag_write AND update in the same cycle: flag_write wins, update discarded.
- shadow_empty = (count == 0); shadow_full = (count == SHADOW_DEPTH). Both derived from the registered count.
- stack_err is sticky until err_clear or reset. If err_clear and a new error occur in the same cycle, the error wins and stack_err = 1.
- Stack is LIFO, implemented as a count-indexed register array; no wrap-around.

Test Plan:
- Reset, then update class 01 with a=8'h7F, b=8'h01, result=8'h80, alu_carry=0 -> next cycle carry=0, overflow=1, zero=0, negative=1.
- Chained compare: class 10 with a=8'h34, b=8'h34, result=8'h00, alu_carry=0 -> zero=1. Then class 11 with a=8'h12, b=8'h13, result=8'hFF, alu_carry=1 -> zero=0, carry=1, negative=1. Then class 11 with result=8'h00 -> zero stays 0.
- Logic op after flags C=1, V=1: update class 00 with result=8'h00 -> carry=1 kept, overflow=0, zero=1, negative=0.
- Shadow stack: flag_write 4'b1010, then save; in the same cycle as save, update with class 00, result=8'h01. Next cycle flags={C1,V0,Z0,N0} and shadow_empty=0. Then restore -> flags=4'b1010, shadow_empty=1.
- Overflow and underflow of the stack: with SHADOW_DEPTH=4, 5 saves -> shadow_full=1 after the 4th, stack_err=1 after the 5th, stack count stays 4. err_clear -> stack_err=0. 5 restores -> flags equal the first pushed value after the 4th restore, stack_err=1 after the 5th.
- Conflicts and reset: save+restore in the same cycle -> stack_err=1, flags and count unchanged. flag_write 4'b0001 together with update -> flags=4'b0001. Assert rst_n low mid-sequence between clock edges -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/status_flags.sv
// ---------------------------------------------------------------------------
// status_flags
//
// Owns the CPU condition flags (carry, overflow, zero, negative) that the
// branch checker consumes. Flags are loaded from ALU results, written
// directly, or restored from a small LIFO shadow stack that preserves them
// across interrupt entry and return.
//
// Ports:
//   clk, rst_n      - rising-edge clock, asynchronous active-low reset
//   update          - load flags from the ALU result this cycle
//   op_class        - 00 logic, 01 add, 10 sub, 11 chained sub/compare
//   a, b, result    - ALU operands (b not pre-inverted) and ALU result
//   alu_carry       - ALU carry-out (add) or borrow-out (sub)
//   flag_write      - direct write of all flags from flag_wdata
//   flag_wdata      - {carry, overflow, zero, negative}
//   save / restore  - push / pop the flags on the shadow stack
//   err_clear       - clear the sticky stack_err
//   carry, overflow, zero, negative - registered flags
//   shadow_empty    - stack holds no entries
//   shadow_full     - stack holds SHADOW_DEPTH entries
//   stack_err       - sticky push-on-full, pop-on-empty or save+restore
// ---------------------------------------------------------------------------
module status_flags #(
  parameter int WIDTH        = 8,
  parameter int SHADOW_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             update,
  input  logic [1:0]       op_class,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] result,
  input  logic             alu_carry,
  input  logic             flag_write,
  input  logic [3:0]       flag_wdata,
  input  logic             save,
  input  logic             restore,
  input  logic             err_clear,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             shadow_empty,
  output logic             shadow_full,
  output logic             stack_err
);

  localparam int M  = WIDTH - 1;
  localparam int AW = $clog2(SHADOW_DEPTH);
  localparam int CW = AW + 1;

  // Flag vector layout is {carry, overflow, zero, negative} everywhere.
  logic [3:0]    flags_q;
  logic [3:0]    upd_flags;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_m1;
  logic [AW-1:0] top_idx;
  logic [AW-1:0] wr_idx;
  logic [3:0]    stack_mem [SHADOW_DEPTH];
  logic          err_q;

  logic stack_empty;
  logic stack_full;
  logic conflict;
  logic pop_err;
  logic push_err;
  logic new_err;
  logic do_pop;
  logic do_push;
  logic live_ok;

  logic a_msb;
  logic b_msb;
  logic res_msb;
  logic res_zero;
  logic add_ovf;
  logic sub_ovf;

  // Stack occupancy and the indices of the top entry and next free slot.
  // wr_idx is only used while the stack is not full, so it always fits.
  assign stack_empty = (count_q == '0);
  assign stack_full  = (count_q == CW'(SHADOW_DEPTH));
  assign count_m1    = count_q - CW'(1);
  assign top_idx     = count_m1[AW-1:0];
  assign wr_idx      = count_q[AW-1:0];

  // Request arbitration. A restore blocks every live-flag change this cycle
  // (whether it succeeds, fails on empty, or collides with save), while a
  // save never blocks the live flags.
  assign conflict = save & restore;
  assign pop_err  = restore & ~save & stack_empty;
  assign push_err = save & ~restore & stack_full;
  assign new_err  = conflict | pop_err | push_err;
  assign do_pop   = restore & ~save & ~stack_empty;
  assign do_push  = save & ~restore & ~stack_full;
  assign live_ok  = ~restore;

  assign a_msb    = a[M];
  assign b_msb    = b[M];
  assign res_msb  = result[M];
  assign res_zero = (result == '0);
  assign add_ovf  = (a_msb == b_msb) && (res_msb != a_msb);
  assign sub_ovf  = (a_msb != b_msb) && (res_msb != a_msb);

  // Flags an update would produce. The chained class ANDs in the current
  // zero so a multi-byte compare reports zero only if every byte matched.
  always_comb begin
    upd_flags = flags_q;
    case (op_class)
      2'b00:   upd_flags = {flags_q[3], 1'b0, res_zero, res_msb};
      2'b01:   upd_flags = {alu_carry, add_ovf, res_zero, res_msb};
      2'b10:   upd_flags = {alu_carry, sub_ovf, res_zero, res_msb};
      default: upd_flags = {alu_carry, sub_ovf, res_zero & flags_q[1], res_msb};
    endcase
  end

  // Live flags: a successful pop wins, then direct write, then ALU update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else if (do_pop) begin
      flags_q <= stack_mem[top_idx];
    end else if (live_ok && flag_write) begin
      flags_q <= flag_wdata;
    end else if (live_ok && update) begin
      flags_q <= upd_flags;
    end
  end

  // Stack depth counter; no wrap-around, errors leave it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (do_pop) begin
      count_q <= count_m1;
    end else if (do_push) begin
      count_q <= count_q + CW'(1);
    end
  end

  // Stack storage. A push captures the flags as they were at the start of
  // the cycle, before any same-cycle write or update lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SHADOW_DEPTH; i++) begin
        stack_mem[i] <= 4'b0000;
      end
    end else if (do_push) begin
      stack_mem[wr_idx] <= flags_q;
    end
  end

  // Sticky error; a fresh error beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (new_err) begin
      err_q <= 1'b1;
    end else if (err_clear) begin
      err_q <= 1'b0;
    end
  end

  assign {carry, overflow, zero, negative} = flags_q;
  assign shadow_empty = stack_empty;
  assign shadow_full  = stack_full;
  assign stack_err    = err_q;

endmodule
